// File: rtl/rsc_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rsc_encoder: rate-1/2 recursive systematic convolutional encoder,        |
// | feedback 1+D^2+D^3, parity 1+D+D^3, optional 3-bit trellis termination.  |
// | Build option: RSC_TERMINATION_EN enables term/tail_active/done.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rsc_encoder (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic enable,
  input  logic data_in,
  input  logic term,
  output logic sys_out,
  output logic par_out,
  output logic out_valid,
  output logic tail_active,
  output logic done
);

  // Trellis state packed as {s2, s1, s0}; s0 is the newest bit.
  logic [2:0] r_st;
  logic       r_sys;
  logic       r_par;
  logic       r_valid;
  logic [2:0] w_st_nxt;
  logic       w_sys_nxt;
  logic       w_par_nxt;
  logic       w_valid_nxt;
  logic       w_fb;

  assign w_fb = data_in ^ r_st[1] ^ r_st[2];

`ifdef RSC_TERMINATION_EN
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    TAIL1 = 2'd1,
    TAIL2 = 2'd2,
    TAIL3 = 2'd3
  } fsm_t;

  fsm_t r_fsm;
  fsm_t w_fsm_nxt;
  logic r_tail;
  logic r_done;
  logic w_tail_nxt;
  logic w_done_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm  <= RUN;
      r_tail <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_tail <= w_tail_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign tail_active = r_tail;
  assign done        = r_done;
`else
  logic w_unused_term;
  assign w_unused_term = term;
  assign tail_active   = 1'b0;
  assign done          = 1'b0;
`endif

  always_comb begin
    w_st_nxt    = r_st;
    w_sys_nxt   = r_sys;
    w_par_nxt   = r_par;
    w_valid_nxt = 1'b0;
`ifdef RSC_TERMINATION_EN
    w_fsm_nxt   = r_fsm;
    w_tail_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
`endif
    if (clr) begin
      w_st_nxt = 3'b000;
`ifdef RSC_TERMINATION_EN
      w_fsm_nxt = RUN;
    end else if (r_fsm != RUN) begin
      // Tail input d = s1^s2 cancels the feedback, so a zero shifts in.
      w_sys_nxt   = r_st[1] ^ r_st[2];
      w_par_nxt   = r_st[0] ^ r_st[2];
      w_st_nxt    = {r_st[1], r_st[0], 1'b0};
      w_valid_nxt = 1'b1;
      w_tail_nxt  = 1'b1;
      w_done_nxt  = (r_fsm == TAIL3);
      case (r_fsm)
        TAIL1:   w_fsm_nxt = TAIL2;
        TAIL2:   w_fsm_nxt = TAIL3;
        default: w_fsm_nxt = RUN;
      endcase
    end else if (term) begin
      w_fsm_nxt = TAIL1;
`endif
    end else if (enable) begin
      w_sys_nxt   = data_in;
      w_par_nxt   = w_fb ^ r_st[0] ^ r_st[2];
      w_st_nxt    = {r_st[1], r_st[0], w_fb};
      w_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st    <= 3'b000;
      r_sys   <= 1'b0;
      r_par   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      r_sys   <= w_sys_nxt;
      r_par   <= w_par_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign sys_out   = r_sys;
  assign par_out   = r_par;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rsc_encoder.sv
`default_nettype none
// Scoreboard bench for rsc_encoder: reference model pushes expected outputs,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_rsc_encoder;

  logic clk = 1'b0;
  logic reset, clr, enable, data_in, term;
  logic sys_out, par_out, out_valid, tail_active, done;

  int checks = 0;
  int errors = 0;

  // Expected entry: {sys, par, tail_active, done}
  logic [3:0] q[$];
  logic [2:0] m_st;     // {s2, s1, s0}
  int         m_tail;   // 0 = encoding, 1..3 = tail bit index
  logic       last_sys, last_par;

  rsc_encoder dut (
    .clk(clk), .reset(reset), .clr(clr), .enable(enable), .data_in(data_in),
    .term(term), .sys_out(sys_out), .par_out(par_out), .out_valid(out_valid),
    .tail_active(tail_active), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic c, input logic e, input logic d, input logic t);
    logic a, p, sd;
    if (c) begin
      m_st   = 3'b000;
      m_tail = 0;
    end
`ifdef RSC_TERMINATION_EN
    else if (m_tail != 0) begin
      sd = ^(m_st & 3'b110);
      p  = ^(m_st & 3'b101);
      q.push_back({sd, p, 1'b1, (m_tail == 3)});
      m_st   = {m_st[1:0], 1'b0};
      m_tail = (m_tail == 3) ? 0 : m_tail + 1;
    end else if (t) begin
      m_tail = 1;
    end
`endif
    else if (e) begin
      a = d ^ (^(m_st & 3'b110));
      p = ^({m_st, a} & 4'b1011);
      q.push_back({d, p, 1'b0, 1'b0});
      m_st = {m_st[1:0], a};
    end
  endtask

  task automatic cycle(input logic c, input logic e, input logic d, input logic t);
    @(posedge clk);
    #1;
    clr = c; enable = e; data_in = d; term = t;
    model_step(c, e, d, t);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({sys_out, par_out, out_valid, tail_active, done} !== 5'b0) begin
      errors++;
      $display("FAIL %s: outputs sys/par/valid/tail/done=%b, required 00000", name,
               {sys_out, par_out, out_valid, tail_active, done});
    end
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    reset = 1'b0; clr = 1'b0; enable = 1'b0; term = 1'b0; data_in = 1'b0;
    #1;
    check_zero(name);
    q.delete();
    m_st = 3'b000; m_tail = 0;
    last_sys = 1'b0; last_par = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (out_valid) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: out_valid=1 with no expected entry, sys/par/tail/done=%b",
                   {sys_out, par_out, tail_active, done});
        end else begin
          logic [3:0] exp;
          exp = q.pop_front();
          if ({sys_out, par_out, tail_active, done} !== exp) begin
            errors++;
            $display("FAIL output: sys/par/tail/done got %b, expected %b at %0t",
                     {sys_out, par_out, tail_active, done}, exp, $time);
          end
          last_sys = exp[3];
          last_par = exp[2];
        end
      end else if ({tail_active, done, sys_out, par_out} !== {2'b00, last_sys, last_par}) begin
        errors++;
        $display("FAIL idle: tail/done/sys/par got %b, expected %b at %0t",
                 {tail_active, done, sys_out, par_out}, {2'b00, last_sys, last_par}, $time);
      end
    end
  end

  initial begin
    reset = 1'b0; clr = 1'b0; enable = 1'b0; data_in = 1'b0; term = 1'b0;
    m_st = 3'b000; m_tail = 0; last_sys = 1'b0; last_par = 1'b0;
    #1;
    check_zero("reset_initial");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Known 1,0,0,0 sequence followed by termination
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 0);

    // Clear during the second tail bit, then encode a 1 from state 000
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);

    // term together with enable, enable held through the tail
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);

    // Reset in the middle of a run / tail
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 1);
    do_reset("reset_mid_tail");
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("reset_random");
      end else begin
        cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
      end
    end

    repeat (6) cycle(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never appeared, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsc_encoder.md
RSC_ENCODER -- requirements
Module: rsc_encoder

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port clr  input  1  synchronous clear of trellis state and control FSM, driven by the block controller.
REQ-004 SHALL have port enable  input  1  encode data_in this cycle.
REQ-005 SHALL have port data_in  input  1  information bit, sampled when enable=1.
REQ-006 SHALL have port term  input  1  single-cycle request to start trellis termination.
REQ-007 SHALL have port sys_out  output  1  registered systematic bit.
REQ-008 SHALL have port par_out  output  1  registered parity bit.
REQ-009 SHALL have port out_valid  output  1  sys_out/par_out valid this cycle.
REQ-010 SHALL have port tail_active  output  1  current output is a tail bit.
REQ-011 SHALL have port done  output  1  one-cycle pulse coincident with the third tail output.

Function
REQ-012 SHALL hold a 3-bit trellis state s0 (newest), s1, s2; feedback g0 = 1+D^2+D^3, parity g1 = 1+D+D^3.
REQ-013 Encode cycle (FSM RUN, enable=1): a = d^s1^s2; sys_out<=d; par_out<=a^s0^s2; out_valid<=1; next state (s0,s1,s2)<=(a,s0,s1).
REQ-014 Latency SHALL be one cycle from the enable sample to out_valid.
REQ-015 RUN with enable=0 and no term: state held; out_valid<=0; sys_out/par_out hold their last values.
REQ-016 FSM states SHALL be RUN, TAIL1, TAIL2, TAIL3; term=1 in RUN moves to TAIL1.
REQ-017 Each TAIL state: d = s1^s2 (forces a=0); sys_out<=d; par_out<=s0^s2; out_valid<=1; tail_active<=1; state shifts with a=0; advances TAIL1->TAIL2->TAIL3->RUN.
REQ-018 done SHALL be 1 together with the TAIL3 output only; trellis state SHALL be 000 afterwards.
REQ-019 Priority: clr > term > enable; term and enable in the same RUN cycle start termination and discard data_in.
REQ-020 enable and term SHALL be ignored in TAIL1-TAIL3.
REQ-021 clr in any state: state<=000, FSM<=RUN, out_valid/tail_active/done<=0 on the next edge; tail aborted.

Reset
REQ-022 reset low SHALL immediately force state=000, FSM=RUN, sys_out=par_out=out_valid=tail_active=done=0.
REQ-023 Deassertion SHALL take effect on the first clk edge after reset returns high; reset during a tail aborts it with no done pulse.

Configuration
REQ-024 Macro RSC_TERMINATION_EN SHALL gate termination logic.
REQ-025 Defined: termination behaviour as REQ-016 to REQ-020.
REQ-026 Undefined: term ignored, FSM reduced to RUN only, tail_active and done tied to 0, encode path unchanged.

Verification
REQ-027 Assert reset mid-run -> all outputs 0 at once, state 000.
REQ-028 From state 000, enable=1, data_in 1,0,0,0 -> sys_out 1,0,0,0, par_out 1,1,1,1, out_valid 1 for 4 cycles, one cycle late.
REQ-029 Continue REQ-028 with term pulse -> tail sys_out 1,0,1, par_out 1,1,1, tail_active 1x3, done on 3rd, state 000.
REQ-030 clr during TAIL2 -> next cycle out_valid=0, no done, state 000; next enable data 1 gives par_out 1.
REQ-031 term and enable=1 same cycle; enable held 1 through tail -> data_in discarded, exactly 3 tail outputs, then encoding resumes.
REQ-032 Macro undefined: term pulse with enable=0 -> out_valid stays 0, tail_active=done=0.
